fb_write_scheduler: RTL and testbench

Sequencer and arbiter for the double-buffered 320x240 RGB332 framebuffer. Shares the single back-buffer write port between the rasterizer and the CPU/AXI path, and defers end-of-frame swaps to the vsync falling edge. After each swap it optionally clears the new back buffer. It sits between the draw sources and the framebuffer BRAM pair, next to the HDMI scan-out logic that consumes `front_sel`.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_rr_arbiter.sv | 38 +++
 rtl/fb_write_scheduler.sv | 148 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and constants for the framebuffer write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int unsigned FB_H_RES  = 320;
    localparam int unsigned FB_V_RES  = 240;
    localparam int unsigned FB_PIXELS = FB_H_RES * FB_V_RES;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] rgb332_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_SWAP    = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_DONE    = 3'd4
    } fb_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_rr_arbiter.sv
// ============================================================================
// Module      : fb_rr_arbiter
// Description : Two-input round-robin arbiter (rast / cpu) with its own pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_rast,
    input  logic i_req_cpu,
    output logic o_gnt_rast,
    output logic o_gnt_cpu
);

    // 0: rast has priority on a tie, 1: cpu has priority
    logic r_ptr_cpu;

    always_comb begin
        o_gnt_rast = i_en & i_req_rast & (~i_req_cpu | ~r_ptr_cpu);
        o_gnt_cpu  = i_en & i_req_cpu  & (~i_req_rast | r_ptr_cpu);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_cpu <= 1'b0;
        end else if (o_gnt_rast) begin
            r_ptr_cpu <= 1'b1;
        end else if (o_gnt_cpu) begin
            r_ptr_cpu <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_write_scheduler.sv
// ============================================================================
// Module      : fb_write_scheduler
// Description : Back-buffer write arbiter and vsync-aligned buffer swap
//               sequencer. Define FB_CLEAR_EN to clear the new back buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              rast_req,
    input  logic [ADDR_W-1:0] rast_addr,
    input  logic [DATA_W-1:0] rast_data,
    output logic              rast_gnt,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    input  logic              frame_done,
    output logic              swap_ack,
    input  logic              vsync,
    input  logic [DATA_W-1:0] clear_color,
    output logic              front_sel,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_PIXELS = ADDR_W'(H_RES * V_RES);

    fb_sched_state_t   r_state;
    fb_sched_state_t   w_next;
    logic              r_vsync_q;
    logic              r_front_sel;
    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [DATA_W-1:0] r_fb_din;
    logic              w_grant_en;
    logic              w_vs_fall;

    assign w_grant_en = (r_state == ST_IDLE) & ~arst;
    assign w_vs_fall  = r_vsync_q & ~vsync;

    fb_rr_arbiter u_arb (
        .clk        (aclk),
        .rst        (arst),
        .i_en       (w_grant_en),
        .i_req_rast (rast_req),
        .i_req_cpu  (cpu_req),
        .o_gnt_rast (rast_gnt),
        .o_gnt_cpu  (cpu_gnt)
    );

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    logic [ADDR_W-1:0] r_clear_cnt;

    // Saturates on the last pixel; DONE is entered on that same edge
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_clear_cnt <= '0;
        end else if (r_state == ST_SWAP) begin
            r_clear_cnt <= '0;
        end else if (r_state == ST_CLEAR && r_clear_cnt != c_LAST_ADDR) begin
            r_clear_cnt <= r_clear_cnt + 1'b1;
        end
    end
`else
    logic w_unused_clear;
    assign w_unused_clear = ^clear_color;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (frame_done && !rast_gnt && !cpu_gnt) w_next = ST_WAIT_VS;
            ST_WAIT_VS: if (w_vs_fall) w_next = ST_SWAP;
`ifdef FB_CLEAR_EN
            ST_SWAP:    w_next = ST_CLEAR;
            ST_CLEAR:   if (r_clear_cnt == c_LAST_ADDR) w_next = ST_DONE;
`else
            ST_SWAP:    w_next = ST_DONE;
`endif
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_vsync_q   <= 1'b1;
            r_front_sel <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vsync_q <= vsync;
            if (r_state == ST_SWAP) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // Out-of-range addresses are accepted but never reach the BRAM
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_din  <= '0;
        end else begin
            r_fb_we <= 1'b0;
            if (rast_gnt) begin
                r_fb_we   <= (rast_addr < c_PIXELS);
                r_fb_addr <= rast_addr;
                r_fb_din  <= rast_data;
            end else if (cpu_gnt) begin
                r_fb_we   <= (cpu_addr < c_PIXELS);
                r_fb_addr <= cpu_addr;
                r_fb_din  <= cpu_data;
            end
`ifdef FB_CLEAR_EN
            else if (r_state == ST_CLEAR) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= r_clear_cnt;
                r_fb_din  <= clear_color;
            end
`endif
        end
    end

    assign front_sel = r_front_sel;
    assign fb_we     = r_fb_we;
    assign fb_addr   = r_fb_addr;
    assign fb_din    = r_fb_din;
    assign swap_ack  = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
// ============================================================================
// Module      : tb_fb_write_scheduler
// Description : Directed self-checking bench for fb_write_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_write_scheduler;

    localparam int N_PIX = 76800;

    logic        aclk;
    logic        arst;
    logic        rast_req;
    logic [16:0] rast_addr;
    logic [7:0]  rast_data;
    logic        rast_gnt;
    logic        cpu_req;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_gnt;
    logic        frame_done;
    logic        swap_ack;
    logic        vsync;
    logic [7:0]  clear_color;
    logic        front_sel;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_din;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fb_write_scheduler dut (
        .aclk        (aclk),
        .arst        (arst),
        .rast_req    (rast_req),
        .rast_addr   (rast_addr),
        .rast_data   (rast_data),
        .rast_gnt    (rast_gnt),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_gnt     (cpu_gnt),
        .frame_done  (frame_done),
        .swap_ack    (swap_ack),
        .vsync       (vsync),
        .clear_color (clear_color),
        .front_sel   (front_sel),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .busy        (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        arst = 1'b1; rast_req = 1'b1; cpu_req = 1'b1; frame_done = 1'b0; vsync = 1'b1;
        rast_addr = '0; rast_data = '0; cpu_addr = '0; cpu_data = '0; clear_color = 8'h03;
        tick; tick;
        checks++;
        if ({rast_gnt, cpu_gnt, swap_ack, fb_we, busy, front_sel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rast_gnt, cpu_gnt, swap_ack, fb_we, busy, front_sel});
        end
        checks++;
        if ({fb_addr, fb_din} !== 25'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0", fb_addr, fb_din);
        end
        arst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({rast_gnt, cpu_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_alternate[%0d]: got %b expected %b", i, {rast_gnt, cpu_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick;
        end
        rast_req = 1'b0; cpu_req = 1'b0;
        tick;
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_write: got %b expected 0", fb_we);
        end
    endtask

    task automatic test_rast_write;
        rast_req = 1'b1; rast_addr = 17'd321; rast_data = 8'hE0;
        #1;
        checks++;
        if ({rast_gnt, cpu_gnt, fb_we} !== 3'b100) begin
            errors++;
            $display("FAIL rast_gnt: got %b expected 100", {rast_gnt, cpu_gnt, fb_we});
        end
        tick;
        rast_req = 1'b0;
        checks++;
        if ({fb_we, fb_addr, fb_din} !== {1'b1, 17'd321, 8'hE0}) begin
            errors++;
            $display("FAIL rast_write: got we=%b addr=%0d din=%h expected we=1 addr=321 din=e0", fb_we, fb_addr, fb_din);
        end
        tick;
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL rast_write_single: got %b expected 0", fb_we);
        end
    endtask

    task automatic test_cpu_oob;
        cpu_req = 1'b1; cpu_addr = 17'd76800; cpu_data = 8'h55;
        #1;
        checks++;
        if ({rast_gnt, cpu_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL cpu_oob_gnt: got %b expected 01", {rast_gnt, cpu_gnt});
        end
        tick;
        cpu_addr = 17'd76799; cpu_data = 8'hA5;
        checks++;
        if (fb_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_oob_discard: got fb_we=%b expected 0", fb_we);
        end
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cpu_lone_gnt: got %b expected 1", cpu_gnt);
        end
        tick;
        cpu_req = 1'b0;
        checks++;
        if ({fb_we, fb_addr, fb_din} !== {1'b1, 17'd76799, 8'hA5}) begin
            errors++;
            $display("FAIL cpu_last_pixel: got we=%b addr=%0d din=%h expected we=1 addr=76799 din=a5", fb_we, fb_addr, fb_din);
        end
        tick;
    endtask

    task automatic test_vsync_ignored;
        vsync = 1'b0;
        tick; tick;
        checks++;
        if ({busy, front_sel, swap_ack} !== 3'b000) begin
            errors++;
            $display("FAIL vsync_idle_ignored: got %b expected 000", {busy, front_sel, swap_ack});
        end
        vsync = 1'b1;
        tick;
    endtask

    task automatic test_abort;
        frame_done = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_wait_busy: got %b expected 1", busy);
        end
        vsync = 1'b0;
        tick;
        checks++;
        if ({busy, front_sel} !== 2'b10) begin
            errors++;
            $display("FAIL abort_swap_state: got %b expected 10", {busy, front_sel});
        end
        tick;
        checks++;
        if (front_sel !== 1'b1) begin
            errors++;
            $display("FAIL abort_toggle: got %b expected 1", front_sel);
        end
`ifdef FB_CLEAR_EN
        repeat (1000) tick;
        checks++;
        if ({fb_we, fb_addr, fb_din} !== {1'b1, 17'd999, 8'h03}) begin
            errors++;
            $display("FAIL abort_clear_progress: got we=%b addr=%0d din=%h expected we=1 addr=999 din=03", fb_we, fb_addr, fb_din);
        end
`else
        checks++;
        if (swap_ack !== 1'b1) begin
            errors++;
            $display("FAIL abort_done_state: got swap_ack=%b expected 1", swap_ack);
        end
`endif
        #3;
        arst = 1'b1;
        #1;
        checks++;
        if ({fb_we, front_sel, busy, swap_ack, rast_gnt, cpu_gnt} !== 6'b0) begin
            errors++;
            $display("FAIL abort_async_reset: got %b expected 000000", {fb_we, front_sel, busy, swap_ack, rast_gnt, cpu_gnt});
        end
        frame_done = 1'b0; vsync = 1'b1;
        rast_req = 1'b1; cpu_req = 1'b1; rast_addr = 17'd7; rast_data = 8'h1C;
        #2;
        arst = 1'b0;
        #1;
        checks++;
        if ({rast_gnt, cpu_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL abort_regrant: got %b expected 10", {rast_gnt, cpu_gnt});
        end
        tick;
        rast_req = 1'b0; cpu_req = 1'b0;
        checks++;
        if ({fb_we, fb_addr, fb_din} !== {1'b1, 17'd7, 8'h1C}) begin
            errors++;
            $display("FAIL abort_post_write: got we=%b addr=%0d din=%h expected we=1 addr=7 din=1c", fb_we, fb_addr, fb_din);
        end
        tick;
    endtask

    task automatic test_swap;
        int bad;
        bad = 0;
        frame_done = 1'b1; rast_req = 1'b1; rast_addr = 17'd5; rast_data = 8'h11;
        #1;
        checks++;
        if ({rast_gnt, busy} !== 2'b10) begin
            errors++;
            $display("FAIL swap_grant_first: got %b expected 10", {rast_gnt, busy});
        end
        tick;
        rast_req = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL swap_defer_wait: got busy=%b expected 0", busy);
        end
        tick;
        rast_req = 1'b1; cpu_req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if ({rast_gnt, cpu_gnt, busy, front_sel} !== 4'b0010) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_vs_hold: got %0d bad cycles expected 0", bad);
        end
        rast_req = 1'b0; cpu_req = 1'b0; vsync = 1'b0;
        tick;
        checks++;
        if (front_sel !== 1'b0) begin
            errors++;
            $display("FAIL swap_early_toggle: got %b expected 0", front_sel);
        end
        tick;
        checks++;
        if (front_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_toggle: got %b expected 1", front_sel);
        end
`ifdef FB_CLEAR_EN
        checks++;
        if ({swap_ack, fb_we} !== 2'b00) begin
            errors++;
            $display("FAIL clear_start: got %b expected 00", {swap_ack, fb_we});
        end
        bad = 0;
        for (int k = 0; k < N_PIX; k++) begin
            tick;
            if (fb_we !== 1'b1 || fb_addr !== 17'(k) || fb_din !== 8'h03 || swap_ack !== (k == N_PIX - 1)) begin
                if (bad == 0)
                    $display("FAIL clear_seq[%0d]: got we=%b addr=%0d din=%h ack=%b expected we=1 addr=%0d din=03 ack=%0d",
                             k, fb_we, fb_addr, fb_din, swap_ack, k, (k == N_PIX - 1));
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_fill: got %0d bad cycles expected 0", bad);
        end
`else
        checks++;
        if ({swap_ack, fb_we} !== 2'b10) begin
            errors++;
            $display("FAIL swap_ack_latency: got %b expected 10", {swap_ack, fb_we});
        end
`endif
        frame_done = 1'b0; vsync = 1'b1;
        tick;
        checks++;
        if ({swap_ack, busy, fb_we, front_sel} !== 4'b0001) begin
            errors++;
            $display("FAIL swap_finish: got %b expected 0001", {swap_ack, busy, fb_we, front_sel});
        end
    endtask

    initial begin
        test_reset;
        test_rast_write;
        test_cpu_oob;
        test_vsync_ignored;
        test_abort;
        test_swap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
